// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit owning the HI/LO registers.
// One operand bit per cycle in MUL/DIV, then one FIX cycle applies signs and commits.
module md_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   input  logic [5:0]      opcode,
   input  logic [5:0]      funct,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   output logic            stall,
   output logic            busy,
   output logic [XLEN-1:0] md_result,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic [1:0]      dbg_state   // 0 IDLE, 1 MUL, 2 DIV, 3 FIX
);

   localparam int CW = $clog2(XLEN);

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_busy;
   logic [CW-1:0]       r_count;
   logic [XLEN-1:0]     r_a;
   logic [XLEN-1:0]     r_b;
   logic [2*XLEN-1:0]   r_acc;
   logic                r_neg_a;
   logic                r_neg_b;
   logic                r_is_div;
   logic [XLEN-1:0]     r_hi;
   logic [XLEN-1:0]     r_lo;

   logic                w_op_zero;
   logic                w_is_mfhi;
   logic                w_is_mthi;
   logic                w_is_mflo;
   logic                w_is_mtlo;
   logic                w_is_mul;
   logic                w_is_div;
   logic                w_md_class;
   logic                w_accept;
   logic                w_signed;
   logic                w_rs_neg;
   logic                w_rt_neg;
   logic [XLEN-1:0]     w_rs_mag;
   logic [XLEN-1:0]     w_rt_mag;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_step;
   logic [XLEN:0]       w_div_sh;
   logic [XLEN:0]       w_div_diff;
   logic [2*XLEN-1:0]   w_div_step;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix_hi;
   logic [XLEN-1:0]     w_fix_lo;

   // Decode: only SPECIAL (opcode 0) HI/LO-class functs participate.
   assign w_op_zero  = (opcode == 6'h00);
   assign w_is_mfhi  = w_op_zero & (funct == F_MFHI);
   assign w_is_mthi  = w_op_zero & (funct == F_MTHI);
   assign w_is_mflo  = w_op_zero & (funct == F_MFLO);
   assign w_is_mtlo  = w_op_zero & (funct == F_MTLO);
   assign w_is_mul   = w_op_zero & ((funct == F_MULT) | (funct == F_MULTU));
   assign w_is_div   = w_op_zero & ((funct == F_DIV)  | (funct == F_DIVU));
   assign w_md_class = w_is_mfhi | w_is_mthi | w_is_mflo | w_is_mtlo | w_is_mul | w_is_div;
   assign w_signed   = (funct == F_MULT) | (funct == F_DIV);

   // Handshake: a live HI/LO-class instruction is accepted when busy is low; while busy
   // it sees stall=1 and must be held unchanged by the pipeline until stall drops.
   assign w_accept = issue_valid & w_md_class & ~r_busy;
   assign stall    = issue_valid & w_md_class & r_busy;

   assign w_rs_neg = w_signed & rs_val[XLEN-1];
   assign w_rt_neg = w_signed & rt_val[XLEN-1];
   assign w_rs_mag = w_rs_neg ? (~rs_val + 1'b1) : rs_val;
   assign w_rt_mag = w_rt_neg ? (~rt_val + 1'b1) : rt_val;

   // Shift-add multiply: add multiplicand into the top half, shift the whole accumulator right.
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_b[0] ? r_a : {XLEN{1'b0}})};
   assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};

   // Restoring divide: acc holds {remainder, dividend-becoming-quotient}.
   assign w_div_sh   = r_acc[2*XLEN-2:XLEN-1];
   assign w_div_diff = w_div_sh - {1'b0, r_b};
   assign w_div_step = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

   assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
   assign w_quo  = r_acc[XLEN-1:0];
   assign w_rem  = r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_hi = w_prod[2*XLEN-1:XLEN];
      w_fix_lo = w_prod[XLEN-1:0];
      if (r_is_div) begin
         if (r_b == '0) begin
            // Divide by zero: r_a holds the raw dividend for division ops.
            w_fix_hi = r_a;
            w_fix_lo = '1;
         end else begin
            w_fix_hi = r_neg_a ? (~w_rem + 1'b1) : w_rem;
            w_fix_lo = (r_neg_a ^ r_neg_b) ? (~w_quo + 1'b1) : w_quo;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept & w_is_mul) begin
               w_state_nxt = S_MUL;
            end else if (w_accept & w_is_div) begin
               w_state_nxt = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            if (r_count == '0) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_count  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_is_div <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_accept & (w_is_mul | w_is_div)) begin
                  r_neg_a  <= w_rs_neg;
                  r_neg_b  <= w_rt_neg;
                  r_count  <= CW'(XLEN - 1);
                  r_b      <= w_rt_mag;
                  r_is_div <= w_is_div;
                  if (w_is_mul) begin
                     r_a   <= w_rs_mag;
                     r_acc <= '0;
                  end else begin
                     r_a   <= rs_val;
                     r_acc <= {{XLEN{1'b0}}, w_rs_mag};
                  end
               end else if (w_accept & w_is_mthi) begin
                  r_hi <= rs_val;
               end else if (w_accept & w_is_mtlo) begin
                  r_lo <= rs_val;
               end
            end
            S_MUL: begin
               r_acc   <= w_mul_step;
               r_b     <= r_b >> 1;
               r_count <= r_count - CW'(1);
            end
            S_DIV: begin
               r_acc   <= w_div_step;
               r_count <= r_count - CW'(1);
            end
            S_FIX: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      md_result = '0;
      if (w_accept & w_is_mfhi) begin
         md_result = r_hi;
      end else if (w_accept & w_is_mflo) begin
         md_result = r_lo;
      end
   end

   assign busy      = r_busy;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign dbg_state = r_state;

endmodule
